// File: rtl/ets_timing_checker.sv
// Instruction execution-time checker: measures start->end cycles per tagged instruction,
// compares against the signature_db entry and tracks violations and a sticky alert.
module ets_timing_checker #(
   parameter int MAX_CYCLES   = 1000,
   parameter int ALERT_THRESH = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_start,
   input  logic [5:0]  instr_id,
   input  logic        instr_end,
   output logic [5:0]  sig_rd_addr,
   input  logic [15:0] sig_expected,
   input  logic [7:0]  sig_tolerance,
   input  logic [7:0]  sig_flags,
   output logic        result_valid,
   output logic [5:0]  result_id,
   output logic [15:0] result_cycles,
   output logic [15:0] result_dev,
   output logic        result_viol,
   output logic        result_timeout,
   output logic        overrun_err,
   output logic [15:0] violation_count,
   output logic        alert,
   input  logic        alert_clr
);

   localparam int CW = $clog2(ALERT_THRESH + 1);
   localparam logic [15:0]   MAX_C = 16'(MAX_CYCLES);
   localparam logic [CW-1:0] THR   = CW'(ALERT_THRESH);

   typedef enum logic {IDLE, MEASURE} state_t;

   state_t        state_q, state_d;
   logic [5:0]    cur_id_q, cur_id_d;
   logic [15:0]   cnt_q, cnt_d;
   logic          overrun_q, overrun_d;
   logic          cmp_valid_q, cmp_valid_d;
   logic [5:0]    cmp_id_q, cmp_id_d;
   logic [15:0]   cmp_cnt_q, cmp_cnt_d;
   logic          cmp_to_q, cmp_to_d;
   logic          res_valid_q, res_valid_d;
   logic [5:0]    res_id_q, res_id_d;
   logic [15:0]   res_cycles_q, res_cycles_d;
   logic [15:0]   res_dev_q, res_dev_d;
   logic          res_viol_q, res_viol_d;
   logic          res_to_q, res_to_d;
   logic [15:0]   vcount_q, vcount_d;
   logic [CW-1:0] consec_q, consec_d;
   logic          alert_q, alert_d;
   logic          push;
   logic [15:0]   dev;
   logic          viol;
   logic [CW-1:0] consec_base;
   logic          unused_flags;

   assign unused_flags = ^sig_flags[7:1];

   // Measurement FSM; a timeout takes priority over a coincident end, and a start in the
   // same cycle as an end or timeout opens the next measurement with no gap.
   always_comb begin
      state_d   = state_q;
      cur_id_d  = cur_id_q;
      cnt_d     = cnt_q;
      overrun_d = 1'b0;
      push      = 1'b0;
      cmp_to_d  = cmp_to_q;
      case (state_q)
         IDLE: begin
            if (instr_start) begin
               cur_id_d = instr_id;
               cnt_d    = 16'd1;
               state_d  = MEASURE;
            end
         end
         MEASURE: begin
            if ((cnt_q == MAX_C) || instr_end) begin
               push     = 1'b1;
               cmp_to_d = (cnt_q == MAX_C);
               if (instr_start) begin
                  cur_id_d = instr_id;
                  cnt_d    = 16'd1;
               end else begin
                  state_d = IDLE;
               end
            end else if (instr_start) begin
               overrun_d = 1'b1;
               cur_id_d  = instr_id;
               cnt_d     = 16'd1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      cmp_valid_d = push;
      cmp_id_d    = push ? cur_id_q : cmp_id_q;
      cmp_cnt_d   = push ? cnt_q : cmp_cnt_q;
   end

   // Compare stage against the signature presented for cmp_id_q.
   always_comb begin
      dev  = (cmp_cnt_q >= sig_expected) ? (cmp_cnt_q - sig_expected)
                                         : (sig_expected - cmp_cnt_q);
      viol = sig_flags[0] & (cmp_to_q | (dev > {8'd0, sig_tolerance}));
      res_valid_d  = cmp_valid_q;
      res_id_d     = cmp_valid_q ? cmp_id_q  : res_id_q;
      res_cycles_d = cmp_valid_q ? cmp_cnt_q : res_cycles_q;
      res_dev_d    = cmp_valid_q ? dev       : res_dev_q;
      res_viol_d   = cmp_valid_q ? viol      : res_viol_q;
      res_to_d     = cmp_valid_q ? cmp_to_q  : res_to_q;
   end

   // alert_clr zeroes the run length first so a violation in the same cycle counts from 1.
   always_comb begin
      consec_base = alert_clr ? '0 : consec_q;
      consec_d    = consec_base;
      vcount_d    = vcount_q;
      if (cmp_valid_q) begin
         if (viol) begin
            consec_d = (consec_base == THR) ? THR : consec_base + 1'b1;
            vcount_d = (vcount_q == 16'hFFFF) ? vcount_q : vcount_q + 16'd1;
         end else begin
            consec_d = '0;
         end
      end
      alert_d = (alert_q & ~alert_clr) | (cmp_valid_q & viol & (consec_d == THR));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cur_id_q     <= '0;
         cnt_q        <= '0;
         overrun_q    <= 1'b0;
         cmp_valid_q  <= 1'b0;
         cmp_id_q     <= '0;
         cmp_cnt_q    <= '0;
         cmp_to_q     <= 1'b0;
         res_valid_q  <= 1'b0;
         res_id_q     <= '0;
         res_cycles_q <= '0;
         res_dev_q    <= '0;
         res_viol_q   <= 1'b0;
         res_to_q     <= 1'b0;
         vcount_q     <= '0;
         consec_q     <= '0;
         alert_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_id_q     <= cur_id_d;
         cnt_q        <= cnt_d;
         overrun_q    <= overrun_d;
         cmp_valid_q  <= cmp_valid_d;
         cmp_id_q     <= cmp_id_d;
         cmp_cnt_q    <= cmp_cnt_d;
         cmp_to_q     <= cmp_to_d;
         res_valid_q  <= res_valid_d;
         res_id_q     <= res_id_d;
         res_cycles_q <= res_cycles_d;
         res_dev_q    <= res_dev_d;
         res_viol_q   <= res_viol_d;
         res_to_q     <= res_to_d;
         vcount_q     <= vcount_d;
         consec_q     <= consec_d;
         alert_q      <= alert_d;
      end
   end

   assign sig_rd_addr     = cmp_id_q;
   assign result_valid    = res_valid_q;
   assign result_id       = res_id_q;
   assign result_cycles   = res_cycles_q;
   assign result_dev      = res_dev_q;
   assign result_viol     = res_viol_q;
   assign result_timeout  = res_to_q;
   assign overrun_err     = overrun_q;
   assign violation_count = vcount_q;
   assign alert           = alert_q;

endmodule

// File: tb/tb_ets_timing_checker.sv
// Directed bench for ets_timing_checker with a small combinational signature_db model.
module tb_ets_timing_checker;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_start, instr_end, alert_clr;
   logic [5:0]  instr_id;
   logic [5:0]  sig_rd_addr;
   logic [15:0] sig_expected;
   logic [7:0]  sig_tolerance, sig_flags;
   logic        result_valid, result_viol, result_timeout, overrun_err, alert;
   logic [5:0]  result_id;
   logic [15:0] result_cycles, result_dev, violation_count;

   int n_assert = 0;
   int n_fail   = 0;

   ets_timing_checker dut (
      .clk(clk), .rst(rst),
      .instr_start(instr_start), .instr_id(instr_id), .instr_end(instr_end),
      .sig_rd_addr(sig_rd_addr), .sig_expected(sig_expected),
      .sig_tolerance(sig_tolerance), .sig_flags(sig_flags),
      .result_valid(result_valid), .result_id(result_id),
      .result_cycles(result_cycles), .result_dev(result_dev),
      .result_viol(result_viol), .result_timeout(result_timeout),
      .overrun_err(overrun_err), .violation_count(violation_count),
      .alert(alert), .alert_clr(alert_clr)
   );

   always #5 clk = ~clk;

   // signature_db: id5 {10, tol 2, en}, id7 {3, tol 0, disabled}, id3 {50, tol 5, en}
   always_comb begin
      sig_expected  = 16'd0;
      sig_tolerance = 8'd0;
      sig_flags     = 8'd0;
      case (sig_rd_addr)
         6'd5: begin sig_expected = 16'd10; sig_tolerance = 8'd2; sig_flags = 8'h01; end
         6'd7: begin sig_expected = 16'd3;  sig_tolerance = 8'd0; sig_flags = 8'h00; end
         6'd3: begin sig_expected = 16'd50; sig_tolerance = 8'd5; sig_flags = 8'h01; end
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, 32'(result_valid), 32'd0);
      chk({tag, "_id"}, 32'(result_id), 32'd0);
      chk({tag, "_cycles"}, 32'(result_cycles), 32'd0);
      chk({tag, "_dev"}, 32'(result_dev), 32'd0);
      chk({tag, "_viol"}, 32'(result_viol), 32'd0);
      chk({tag, "_timeout"}, 32'(result_timeout), 32'd0);
      chk({tag, "_overrun"}, 32'(overrun_err), 32'd0);
      chk({tag, "_vcount"}, 32'(violation_count), 32'd0);
      chk({tag, "_alert"}, 32'(alert), 32'd0);
      chk({tag, "_rdaddr"}, 32'(sig_rd_addr), 32'd0);
   endtask

   task automatic chk_res(input string tag, input int id, input int cyc, input int dev,
                          input int viol, input int to, input int vc, input int al);
      chk({tag, "_id"}, 32'(result_id), 32'(id));
      chk({tag, "_cycles"}, 32'(result_cycles), 32'(cyc));
      chk({tag, "_dev"}, 32'(result_dev), 32'(dev));
      chk({tag, "_viol"}, 32'(result_viol), 32'(viol));
      chk({tag, "_timeout"}, 32'(result_timeout), 32'(to));
      chk({tag, "_vcount"}, 32'(violation_count), 32'(vc));
      chk({tag, "_alert"}, 32'(alert), 32'(al));
   endtask

   // Called at a negedge: start now, end len cycles later; returns when the result is visible.
   task automatic run(input string tag, input logic [5:0] id, input int len);
      instr_start = 1'b1;
      instr_id    = id;
      @(negedge clk);
      instr_start = 1'b0;
      wait_n(len - 1);
      instr_end = 1'b1;
      @(negedge clk);
      instr_end = 1'b0;
      chk({tag, "_valid_early"}, 32'(result_valid), 32'd0);
      @(negedge clk);
      chk({tag, "_valid"}, 32'(result_valid), 32'd1);
   endtask

   task automatic clear_alert();
      alert_clr = 1'b1;
      @(negedge clk);
      alert_clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1; instr_start = 1'b0; instr_end = 1'b0; alert_clr = 1'b0; instr_id = '0;
      wait_n(2);
      chk_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // 1: within tolerance
      run("t1", 6'd5, 12);
      chk_res("t1", 5, 12, 2, 0, 0, 0, 0);
      // 2: one beyond tolerance
      run("t2", 6'd5, 13);
      chk_res("t2", 5, 13, 3, 1, 0, 1, 0);
      // 3: consecutive violations raise alert on the third
      run("t3a", 6'd5, 14);
      chk_res("t3a", 5, 14, 4, 1, 0, 2, 0);
      run("t3b", 6'd5, 6);
      chk_res("t3b", 5, 6, 4, 1, 0, 3, 1);
      clear_alert();
      chk("t3_clr_alert", 32'(alert), 32'd0);
      chk("t3_clr_vcount", 32'(violation_count), 32'd3);
      run("t3c", 6'd5, 13);
      run("t3d", 6'd5, 13);
      chk_res("t3d", 5, 13, 3, 1, 0, 5, 0);
      run("t3e", 6'd5, 8);
      chk_res("t3e", 5, 8, 2, 0, 0, 5, 0);
      run("t3f", 6'd5, 13);
      run("t3g", 6'd5, 13);
      chk_res("t3g", 5, 13, 3, 1, 0, 7, 0);

      // 4: back-to-back end id5 / start id7, id7 unchecked
      instr_start = 1'b1; instr_id = 6'd5;
      @(negedge clk);
      instr_start = 1'b0;
      wait_n(11);
      instr_end = 1'b1; instr_start = 1'b1; instr_id = 6'd7;
      @(negedge clk);
      instr_end = 1'b0; instr_start = 1'b0;
      @(negedge clk);
      chk("t4a_valid", 32'(result_valid), 32'd1);
      chk_res("t4a", 5, 12, 2, 0, 0, 7, 0);
      wait_n(2);
      instr_end = 1'b1;
      @(negedge clk);
      instr_end = 1'b0;
      chk("t4b_valid_early", 32'(result_valid), 32'd0);
      @(negedge clk);
      chk("t4b_valid", 32'(result_valid), 32'd1);
      chk_res("t4b", 7, 4, 1, 0, 0, 7, 0);

      // 5a: timeout at MAX_CYCLES
      instr_start = 1'b1; instr_id = 6'd3;
      @(negedge clk);
      instr_start = 1'b0;
      wait_n(999);
      @(negedge clk);
      chk("t5a_valid_early", 32'(result_valid), 32'd0);
      @(negedge clk);
      chk("t5a_valid", 32'(result_valid), 32'd1);
      chk_res("t5a", 3, 1000, 950, 1, 1, 8, 0);

      // 5b: overrun drops id3, id5 measurement restarts at the overrunning start
      instr_start = 1'b1; instr_id = 6'd3;
      @(negedge clk);
      instr_start = 1'b0;
      wait_n(4);
      instr_start = 1'b1; instr_id = 6'd5;
      @(negedge clk);
      instr_start = 1'b0;
      chk("t5b_overrun", 32'(overrun_err), 32'd1);
      @(negedge clk);
      chk("t5b_overrun_pulse", 32'(overrun_err), 32'd0);
      chk("t5b_no_result", 32'(result_valid), 32'd0);
      wait_n(10);
      instr_end = 1'b1;
      @(negedge clk);
      instr_end = 1'b0;
      chk("t5b_valid_early", 32'(result_valid), 32'd0);
      @(negedge clk);
      chk("t5b_valid", 32'(result_valid), 32'd1);
      chk_res("t5b", 5, 12, 2, 0, 0, 8, 0);

      // 6a: violation counter saturation
      force dut.vcount_q = 16'hFFFE;
      @(negedge clk);
      release dut.vcount_q;
      @(negedge clk);
      chk("t6_forced", 32'(violation_count), 32'hFFFE);
      run("t6a", 6'd5, 13);
      chk_res("t6a", 5, 13, 3, 1, 0, 32'hFFFF, 0);
      run("t6b", 6'd5, 13);
      chk_res("t6b", 5, 13, 3, 1, 0, 32'hFFFF, 0);

      // 6b: reset mid-measurement discards it
      instr_start = 1'b1; instr_id = 6'd5;
      @(negedge clk);
      instr_start = 1'b0;
      wait_n(4);
      rst = 1'b1;
      @(negedge clk);
      chk_zero("t6_rst");
      rst = 1'b0;
      instr_end = 1'b1;
      @(negedge clk);
      instr_end = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t6_rst_no_result", 32'(result_valid), 32'd0);
      end
      chk_zero("t6_post");
      run("t6c", 6'd5, 12);
      chk_res("t6c", 5, 12, 2, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
